// File: rtl/pipe_elastic_buffer.sv
// In-order elastic buffer between two pipeline stages.
// Intake stalls behind a faulting entry until that entry drains.
module pipe_elastic_buffer #(
  parameter int DATA_W = 32,
  parameter int EXC_W = 12,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CNT_W-1:0]  count,
  output logic              exc_block
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [EXC_W-1:0]  exc_q  [DEPTH];
  logic [EXC_W-1:0]  exc_d  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exc_block_q, exc_block_d;

  logic full;
  logic push;
  logic pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = ~full & ~exc_block_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign count     = count_q;
  assign exc_block = exc_block_q;
  assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_q[rd_ptr_q] : '0;
  assign out_exc   = out_valid ? exc_q[rd_ptr_q] : '0;

  always_comb begin
    data_d      = data_q;
    pc_d        = pc_q;
    exc_d       = exc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    exc_block_d = exc_block_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      exc_block_d = 1'b0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = in_data;
        pc_d[wr_ptr_q]   = in_pc;
        exc_d[wr_ptr_q]  = in_exc;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // The faulting entry is always the youngest, so it leaves last.
      if (push && (in_exc != '0)) begin
        exc_block_d = 1'b1;
      end else if (pop && exc_block_q && (count_q == CNT_W'(1))) begin
        exc_block_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        exc_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      exc_block_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      pc_q        <= pc_d;
      exc_q       <= exc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      exc_block_q <= exc_block_d;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Bench for pipe_elastic_buffer: DEPTH=2 and DEPTH=4 instances
// checked every cycle against a queue-level model.
module tb_pipe_elastic_buffer;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
    logic [11:0] e;
  } ent_t;

  localparam int DEP [2] = '{2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        flush [2];
  logic        iv    [2];
  logic        ir    [2];
  logic        ov    [2];
  logic        ordy  [2];
  logic        eb    [2];
  logic [31:0] idat  [2];
  logic [31:0] ipc   [2];
  logic [11:0] iexc  [2];
  logic [31:0] odat  [2];
  logic [31:0] opc   [2];
  logic [11:0] oexc  [2];
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_elastic_buffer #(.DATA_W(32), .EXC_W(12), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .in_pc(ipc[0]), .in_exc(iexc[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]),
    .out_pc(opc[0]), .out_exc(oexc[0]),
    .count(cnt0), .exc_block(eb[0])
  );

  pipe_elastic_buffer #(.DATA_W(32), .EXC_W(12), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .in_pc(ipc[1]), .in_exc(iexc[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]),
    .out_pc(opc[1]), .out_exc(oexc[1]),
    .count(cnt1), .exc_block(eb[1])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: an append-only log with monotonically growing read/write totals.
  ent_t log_m [2][1024];
  int   wr_m  [2] = '{0, 0};
  int   rd_m  [2] = '{0, 0};
  bit   blk_m [2] = '{0, 0};
  bit   armed = 0;

  always @(posedge clk) begin
    armed = 1;
    for (int k = 0; k < 2; k++) begin
      int occ;
      occ = wr_m[k] - rd_m[k];
      if (rst || flush[k]) begin
        rd_m[k] = wr_m[k];
        blk_m[k] = 0;
      end else begin
        bit acc_in;
        acc_in = iv[k] && (occ != DEP[k]) && !blk_m[k];
        if (occ != 0 && ordy[k]) begin
          rd_m[k]++;
          if (wr_m[k] == rd_m[k]) blk_m[k] = 0;
        end
        if (acc_in) begin
          log_m[k][wr_m[k] % 1024] = '{idat[k], ipc[k], iexc[k]};
          wr_m[k]++;
          if (iexc[k] != 0) blk_m[k] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        int   occ;
        ent_t h;
        logic [2:0] c;
        occ = wr_m[k] - rd_m[k];
        h = (occ != 0) ? log_m[k][rd_m[k] % 1024] : '0;
        c = (k == 0) ? {1'b0, cnt0} : cnt1;
        chk($sformatf("count%0d", k), 64'(c), 64'(occ));
        chk($sformatf("in_ready%0d", k), 64'(ir[k]),
            64'((occ != DEP[k]) && !blk_m[k]));
        chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(occ != 0));
        chk($sformatf("exc_block%0d", k), 64'(eb[k]), 64'(blk_m[k]));
        chk($sformatf("out_data%0d", k), 64'(odat[k]), 64'(h.d));
        chk($sformatf("out_pc%0d", k), 64'(opc[k]), 64'(h.pc));
        chk($sformatf("out_exc%0d", k), 64'(oexc[k]), 64'(h.e));
        chk($sformatf("bound%0d", k), 64'(c <= 3'(DEP[k])), 64'(1));
      end
    end
  end

  logic [63:0] got1 [$];
  always @(negedge clk) begin
    if (!rst && !flush[1] && ov[1] && ordy[1])
      got1.push_back({odat[1], opc[1]});
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  bit acc [2] = '{0, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; iv[k] = 0; ordy[k] = 0;
      idat[k] = 0; ipc[k] = 0; iexc[k] = 0;
    end
    rst = 1;
    iv[0] = 1; idat[0] = 32'hDEAD;
    repeat (2) tick;
    rst = 0; iv[0] = 0;
    settle;
    chk("rst_in_ready", 64'(ir[0]), 64'(1));
    chk("rst_out_valid", 64'(ov[0]), 64'(0));
    chk("rst_count", 64'(cnt0), 64'(0));
    chk("rst_out_data", 64'(odat[0]), 64'(0));
    chk("rst_out_exc", 64'(oexc[0]), 64'(0));

    // fill and drain
    iv[0] = 1; idat[0] = 32'h11; ipc[0] = 32'h100;
    tick;
    idat[0] = 32'h22; ipc[0] = 32'h104;
    tick;
    iv[0] = 0;
    settle;
    chk("fill_count", 64'(cnt0), 64'(2));
    chk("fill_in_ready", 64'(ir[0]), 64'(0));
    chk("fill_head", 64'(odat[0]), 64'h11);
    ordy[0] = 1;
    tick;
    settle;
    chk("drain1_count", 64'(cnt0), 64'(1));
    chk("drain1_head", 64'(odat[0]), 64'h22);
    chk("drain1_pc", 64'(opc[0]), 64'h104);
    chk("drain1_in_ready", 64'(ir[0]), 64'(1));
    tick;
    settle;
    chk("drain2_count", 64'(cnt0), 64'(0));
    chk("drain2_valid", 64'(ov[0]), 64'(0));
    ordy[0] = 0;

    // concurrent push/pop at count 1
    iv[0] = 1; idat[0] = 32'h33; ipc[0] = 32'h108;
    tick;
    idat[0] = 32'h44; ipc[0] = 32'h10C; ordy[0] = 1;
    tick;
    iv[0] = 0;
    settle;
    chk("conc_count", 64'(cnt0), 64'(1));
    chk("conc_head", 64'(odat[0]), 64'h44);
    tick;
    settle;
    chk("conc_empty", 64'(cnt0), 64'(0));
    ordy[0] = 0;

    // exception block
    iv[0] = 1; idat[0] = 32'h55; ipc[0] = 32'h110; iexc[0] = 12'h004;
    tick;
    idat[0] = 32'h66; ipc[0] = 32'h114; iexc[0] = 12'h000;
    settle;
    chk("exc_block_set", 64'(eb[0]), 64'(1));
    chk("exc_in_ready", 64'(ir[0]), 64'(0));
    chk("exc_head_exc", 64'(oexc[0]), 64'h004);
    tick;
    settle;
    chk("exc_hold_count", 64'(cnt0), 64'(1));
    ordy[0] = 1;
    tick;
    settle;
    chk("exc_pop_count", 64'(cnt0), 64'(0));
    chk("exc_cleared", 64'(eb[0]), 64'(0));
    chk("exc_ready_back", 64'(ir[0]), 64'(1));
    tick;
    iv[0] = 0;
    settle;
    chk("exc_d_in", 64'(cnt0), 64'(1));
    chk("exc_d_head", 64'(odat[0]), 64'h66);
    tick;
    ordy[0] = 0;

    // flush while full
    iv[0] = 1; idat[0] = 32'h77; ipc[0] = 32'h118;
    tick;
    idat[0] = 32'h88; ipc[0] = 32'h11C;
    tick;
    settle;
    chk("pre_flush_count", 64'(cnt0), 64'(2));
    flush[0] = 1; idat[0] = 32'h99; ipc[0] = 32'h120; ordy[0] = 1;
    tick;
    flush[0] = 0; iv[0] = 0; ordy[0] = 0;
    settle;
    chk("flush_count", 64'(cnt0), 64'(0));
    chk("flush_valid", 64'(ov[0]), 64'(0));
    chk("flush_ready", 64'(ir[0]), 64'(1));
    tick;
    settle;
    chk("flush_no_ghost", 64'(ov[0]), 64'(0));

    // wrap-around stream on the DEPTH=4 instance
    begin
      int nxt;
      nxt = 0;
      acc[1] = 0;
      for (int c = 0; c < 400; c++) begin
        tick;
        if (acc[1]) nxt++;
        ordy[1] = 1'($urandom_range(0, 1));
        if (nxt >= 10) begin
          iv[1] = 0;
        end else if (!iv[1] || acc[1]) begin
          iv[1] = ($urandom_range(0, 2) != 0);
          idat[1] = 32'(nxt);
          ipc[1] = 32'h200 + 32'(4 * nxt);
        end
        settle;
        acc[1] = iv[1] & ir[1];
        if (nxt >= 10 && got1.size() >= 10) break;
      end
      iv[1] = 0; ordy[1] = 0;
      chk("wrap_total", 64'(got1.size()), 64'(10));
      for (int i = 0; i < 10 && i < got1.size(); i++)
        chk($sformatf("wrap_item%0d", i), got1[i],
            {32'(i), 32'h200 + 32'(4 * i)});
    end

    // random traffic with faults, flushes and a mid-stream reset
    acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 300; c++) begin
      tick;
      rst = (c == 150);
      for (int k = 0; k < 2; k++) begin
        flush[k] = ($urandom_range(0, 39) == 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
        if (!(iv[k] && !acc[k])) begin
          iv[k] = 1'($urandom_range(0, 1));
          idat[k] = $urandom;
          ipc[k] = $urandom & 32'hFFFF_FFFC;
          iexc[k] = ($urandom_range(0, 7) == 0) ?
                    12'($urandom_range(1, 4095)) : 12'h000;
        end
      end
      settle;
      for (int k = 0; k < 2; k++)
        acc[k] = iv[k] & ir[k] & ~flush[k] & ~rst;
    end
    tick;
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; iv[k] = 0; ordy[k] = 0;
    end
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
